// File: rtl/mtr_drv.sv
// Dual H-bridge PWM generator: signed speed -> complementary hi/lo gate pair with dead time,
// plus blanked over-current qualification and latched shutdown after repeated faulted periods.
//
// state  | meaning
// RUN    | normal PWM, counting consecutive faulted periods
// SHTDWN | over-current shutdown latched, all gates forced off until rst
module mtr_drv #(
  parameter int DEAD      = 32,
  parameter int BLANK     = 128,
  parameter int OVR_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [11:0] lft_spd,
  input  logic signed [11:0] rght_spd,
  input  logic               OVR_I_lft,
  input  logic               OVR_I_rght,
  output logic               lft_hi,
  output logic               lft_lo,
  output logic               rght_hi,
  output logic               rght_lo,
  output logic               PWM_synch,
  output logic               OVR_I_shtdwn
);

  localparam logic [11:0] DEAD12  = 12'(DEAD);
  localparam logic [11:0] WIN_LO  = 12'(DEAD + BLANK);
  localparam logic [3:0]  LIMIT4  = 4'(OVR_LIMIT);
  localparam logic [10:0] CNT_MAX = 11'd2047;

  typedef enum logic {RUN, SHTDWN} state_t;

  state_t      state, state_nxt;
  logic [10:0] cnt;
  logic [10:0] lft_duty, rght_duty;
  logic [3:0]  consec, consec_nxt;
  logic        flt_flag, flag_nxt;
  logic        lft_flt, rght_flt, any_flt, period_end;
  logic        lft_hi_nxt, lft_lo_nxt, rght_hi_nxt, rght_lo_nxt;

  function automatic logic [10:0] duty_of(input logic signed [11:0] spd);
    logic signed [11:0] sat;
    if (spd > 12'sd1023)       sat = 12'sd1023;
    else if (spd < -12'sd1023) sat = -12'sd1023;
    else                       sat = spd;
    return 11'(sat + 12'sd1024);
  endfunction

  function automatic logic hi_on(input logic [10:0] c, input logic [10:0] duty);
    return ({1'b0, c} >= DEAD12) && (c < duty);
  endfunction

  // 12-bit sum so a duty near full scale simply never reaches the lo threshold
  function automatic logic lo_on(input logic [10:0] c, input logic [10:0] duty);
    return {1'b0, c} >= ({1'b0, duty} + DEAD12);
  endfunction

  assign period_end = (cnt == CNT_MAX);
  assign lft_flt    = OVR_I_lft  && ({1'b0, cnt} >= WIN_LO) && (cnt < lft_duty);
  assign rght_flt   = OVR_I_rght && ({1'b0, cnt} >= WIN_LO) && (cnt < rght_duty);
  assign any_flt    = flt_flag | lft_flt | rght_flt;

  always_comb begin
    state_nxt  = state;
    consec_nxt = consec;
    flag_nxt   = any_flt;
    if (state == RUN && period_end) begin
      flag_nxt   = 1'b0;
      consec_nxt = any_flt ? consec + 4'd1 : 4'd0;
      if (consec_nxt == LIMIT4) state_nxt = SHTDWN;
    end
    lft_hi_nxt  = (state_nxt == RUN) && hi_on(cnt, lft_duty);
    lft_lo_nxt  = (state_nxt == RUN) && lo_on(cnt, lft_duty);
    rght_hi_nxt = (state_nxt == RUN) && hi_on(cnt, rght_duty);
    rght_lo_nxt = (state_nxt == RUN) && lo_on(cnt, rght_duty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= 11'd0;
      lft_duty  <= 11'd1024;
      rght_duty <= 11'd1024;
      consec    <= 4'd0;
      flt_flag  <= 1'b0;
      lft_hi    <= 1'b0;
      lft_lo    <= 1'b0;
      rght_hi   <= 1'b0;
      rght_lo   <= 1'b0;
      PWM_synch <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt + 11'd1;
      consec    <= consec_nxt;
      flt_flag  <= flag_nxt;
      lft_hi    <= lft_hi_nxt;
      lft_lo    <= lft_lo_nxt;
      rght_hi   <= rght_hi_nxt;
      rght_lo   <= rght_lo_nxt;
      PWM_synch <= (cnt == 11'd0);
      if (period_end) begin
        lft_duty  <= duty_of(lft_spd);
        rght_duty <= duty_of(rght_spd);
      end
    end
  end

  assign OVR_I_shtdwn = (state == SHTDWN);

endmodule

// File: tb/tb_mtr_drv.sv
// Directed bench for mtr_drv: table of speed/count/gate vectors plus hand sequences for
// mid-period update, blanking, shutdown counting and reset out of shutdown.
module tb_mtr_drv;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [11:0] lft_spd, rght_spd;
  logic              OVR_I_lft, OVR_I_rght;
  logic              lft_hi, lft_lo, rght_hi, rght_lo, PWM_synch, OVR_I_shtdwn;

  int total = 0;
  int bad   = 0;
  int tb_cnt = 0;     // value the DUT counter holds now
  int refl   = 2047;  // counter value the registered outputs currently reflect
  logic ovr_en = 1'b0;
  int ovr_lo = 0, ovr_hi = 0;

  mtr_drv #(.DEAD(32), .BLANK(128), .OVR_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .OVR_I_lft(OVR_I_lft), .OVR_I_rght(OVR_I_rght),
    .lft_hi(lft_hi), .lft_lo(lft_lo), .rght_hi(rght_hi), .rght_lo(rght_lo),
    .PWM_synch(PWM_synch), .OVR_I_shtdwn(OVR_I_shtdwn)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [11:0] l;
    logic [11:0] r;
    int          c;
    logic [3:0]  e;  // {lft_hi, lft_lo, rght_hi, rght_lo}
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (refl cnt %0d)", name, act, exp, refl);
    end
  endtask

  task automatic step();
    logic in_rst;
    in_rst = rst;
    @(posedge clk);
    tb_cnt = in_rst ? 0 : (tb_cnt + 1) % 2048;
    @(negedge clk);
    refl = (tb_cnt + 2047) % 2048;
    OVR_I_lft = ovr_en && (tb_cnt >= ovr_lo) && (tb_cnt <= ovr_hi);
    check("overlap_lft",  int'(lft_hi & lft_lo), 0);
    check("overlap_rght", int'(rght_hi & rght_lo), 0);
    check("pwm_synch",    int'(PWM_synch), (refl == 0) ? 1 : 0);
  endtask

  task automatic run_to(input int c, input bit force_step);
    int n;
    n = 0;
    if (force_step) step();
    while (refl != c && n < 4200) begin
      step();
      n++;
    end
    if (refl != c) begin
      $display("FAIL run_to: timed out at %0d waiting for %0d", refl, c);
      bad++;
      total++;
    end
  endtask

  task automatic check_gates(input string name, input logic [3:0] e);
    check({name, "_lh"}, int'(lft_hi),  int'(e[3]));
    check({name, "_ll"}, int'(lft_lo),  int'(e[2]));
    check({name, "_rh"}, int'(rght_hi), int'(e[1]));
    check({name, "_rl"}, int'(rght_lo), int'(e[0]));
  endtask

  initial begin
    vecs[0]  = '{12'h000, 12'h000,    0, 4'b0000};
    vecs[1]  = '{12'h000, 12'h000,   31, 4'b0000};
    vecs[2]  = '{12'h000, 12'h000,   32, 4'b1010};
    vecs[3]  = '{12'h000, 12'h000, 1023, 4'b1010};
    vecs[4]  = '{12'h000, 12'h000, 1024, 4'b0000};
    vecs[5]  = '{12'h000, 12'h000, 1055, 4'b0000};
    vecs[6]  = '{12'h000, 12'h000, 1056, 4'b0101};
    vecs[7]  = '{12'h000, 12'h000, 2047, 4'b0101};
    vecs[8]  = '{12'h7FF, 12'h800,    0, 4'b0000};
    vecs[9]  = '{12'h7FF, 12'h800,   31, 4'b0000};
    vecs[10] = '{12'h7FF, 12'h800,   32, 4'b1000};
    vecs[11] = '{12'h7FF, 12'h800,   33, 4'b1001};
    vecs[12] = '{12'h7FF, 12'h800, 2046, 4'b1001};
    vecs[13] = '{12'h7FF, 12'h800, 2047, 4'b0001};
    vecs[14] = '{12'h200, 12'hE00,  511, 4'b1010};
    vecs[15] = '{12'h200, 12'hE00,  512, 4'b1000};
    vecs[16] = '{12'h200, 12'hE00,  544, 4'b1001};
    vecs[17] = '{12'h200, 12'hE00, 1535, 4'b1001};
    vecs[18] = '{12'h200, 12'hE00, 1536, 4'b0001};
    vecs[19] = '{12'h200, 12'hE00, 1567, 4'b0001};
    vecs[20] = '{12'h200, 12'hE00, 1568, 4'b0101};
    vecs[21] = '{12'h400, 12'hC20,   32, 4'b1000};
    vecs[22] = '{12'h400, 12'hC20,   63, 4'b1000};
    vecs[23] = '{12'h400, 12'hC20,   64, 4'b1001};
    vecs[24] = '{12'h400, 12'hC20, 2046, 4'b1001};
    vecs[25] = '{12'h400, 12'hC20, 2047, 4'b0001};

    rst = 1'b1;
    lft_spd = '0;
    rght_spd = '0;
    OVR_I_lft = 1'b0;
    OVR_I_rght = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check_gates("reset", 4'b0000);
    check("reset_synch", int'(PWM_synch), 0);
    check("reset_shtdwn", int'(OVR_I_shtdwn), 0);

    // speed/gate table; a new speed pair is loaded at the next period boundary
    for (int i = 0; i < 26; i++) begin
      if (i == 0 || vecs[i].l != vecs[i-1].l || vecs[i].r != vecs[i-1].r) begin
        lft_spd  = vecs[i].l;
        rght_spd = vecs[i].r;
        run_to(2047, 1'b1);
      end
      run_to(vecs[i].c, 1'b0);
      check_gates($sformatf("vec%0d", i), vecs[i].e);
    end

    // mid-period speed change only applies from the next period
    lft_spd  = '0;
    rght_spd = '0;
    run_to(2047, 1'b1);
    run_to(500, 1'b0);
    lft_spd = 12'sd512;
    run_to(1023, 1'b0); check("mid_cur_1023", int'(lft_hi), 1);
    run_to(1024, 1'b0); check("mid_cur_1024", int'(lft_hi), 0);
    run_to(1535, 1'b0); check("mid_cur_1535", int'(lft_hi), 0);
    run_to(2047, 1'b0);
    run_to(1535, 1'b0); check("mid_nxt_1535", int'(lft_hi), 1);
    run_to(1536, 1'b0); check("mid_nxt_1536", int'(lft_hi), 0);

    // over-current entirely inside the blanking window never counts
    ovr_lo = 32;
    ovr_hi = 159;
    ovr_en = 1'b1;
    for (int p = 0; p < 6; p++) begin
      run_to(2047, 1'b1);
      check($sformatf("blank_p%0d", p), int'(OVR_I_shtdwn), 0);
    end
    ovr_en = 1'b0;

    // 3 faulted, 1 clean, 3 faulted: no shutdown; one more faulted period trips it
    ovr_lo = 300;
    ovr_hi = 300;
    for (int p = 0; p < 7; p++) begin
      ovr_en = (p != 3);
      run_to(2047, 1'b1);
      check($sformatf("consec_p%0d", p), int'(OVR_I_shtdwn), 0);
    end
    ovr_en = 1'b1;
    run_to(2046, 1'b1);
    check("trip_pre_shtdwn", int'(OVR_I_shtdwn), 0);
    check("trip_pre_lo", int'(lft_lo), 1);
    run_to(2047, 1'b0);
    ovr_en = 1'b0;
    check("trip_shtdwn", int'(OVR_I_shtdwn), 1);
    check_gates("trip_gates", 4'b0000);
    run_to(500, 1'b0);
    check("held_shtdwn", int'(OVR_I_shtdwn), 1);
    check_gates("held_gates", 4'b0000);

    // reset out of shutdown; first period runs at the reset duty of 1024
    run_to(699, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_gates("rst_gates", 4'b0000);
    check("rst_shtdwn", int'(OVR_I_shtdwn), 0);
    check("rst_synch", int'(PWM_synch), 0);
    check("rst_cnt", tb_cnt, 0);
    run_to(0, 1'b1);
    run_to(1023, 1'b0); check("rst_duty_1023", int'(lft_hi), 1);
    run_to(1024, 1'b0); check("rst_duty_1024", int'(lft_hi), 0);
    run_to(2047, 1'b0);
    run_to(1535, 1'b0); check("resume_1535", int'(lft_hi), 1);
    check("resume_shtdwn", int'(OVR_I_shtdwn), 0);
    run_to(1536, 1'b0); check("resume_1536", int'(lft_hi), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mtr_drv.md
Name: mtr_drv

Overview:
- Downstream consumer of the balance controller's signed 12-bit left/right motor speeds.
- Converts each speed into a complementary high-side/low-side PWM pair with non-overlap dead time, for the two H-bridge motor drivers.
- Watches the drivers' over-current flags with blanking and latches a shutdown after repeated faults.
- Emits a period-start strobe for A2D sample synchronisation.

Parameters:
DEAD, 32, non-overlap time in clocks between one switch of a pair turning off and the other turning on (1..255).
BLANK, 128, clocks after high-side turn-on during which the over-current input is ignored.
OVR_LIMIT, 4, consecutive faulted PWM periods that trigger latched shutdown (1..15).

Ports:
clk  input  1  system clock (50 MHz).
rst  input  1  synchronous active-high reset.
lft_spd  input  12  signed left motor speed.
rght_spd  input  12  signed right motor speed.
OVR_I_lft  input  1  left driver over-current flag, active high.
OVR_I_rght  input  1  right driver over-current flag, active high.
lft_hi  output  1  left high-side gate enable.
lft_lo  output  1  left low-side gate enable.
rght_hi  output  1  right high-side gate enable.
rght_lo  output  1  right low-side gate enable.
PWM_synch  output  1  one-clock pulse at PWM period start.
OVR_I_shtdwn  output  1  latched over-current shutdown indicator.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: cnt=0, both shadow duties=1024, all gate outputs=0, PWM_synch=0, OVR_I_shtdwn=0, fault flags/counters=0, FSM=RUN.
- Counter: 11-bit free-running cnt, 0..2047, wraps to 0. Period = 2048 clocks.
- Duty computation, per side:
  - Saturate the speed to [-1023, +1023]. -2048 maps to -1023; 2047 maps to 1023.
  - duty = sat + 1024, 11 bits, range 1..2047. Zero speed gives 1024 (50%).
- Duty update: shadow duties load from the computed values only on the clock where cnt==2047, so a new duty takes effect starting at cnt==0. Input changes mid-period do not affect the current period.
- Gate outputs are registered. Each output reflects the comparison on the cnt value of the previous clock (1-clock latency). For each side:
  - hi = (DEAD <= cnt < duty).
  - lo = (cnt >= duty+DEAD), evaluated as a 12-bit sum with no wrap. If duty+DEAD > 2047, lo is never asserted that period.
  - If duty <= DEAD, hi is never asserted that period.
  - hi and lo are never high on the same clock, and each is low for at least DEAD clocks around every transition, including across the 2047->0 wrap.
- PWM_synch: registered, high for the one clock following cnt==0.
- Over-current qualification, per side:
  - A fault is qualified when OVR_I_x=1 while DEAD+BLANK <= cnt < duty.
  - Any qualified fault in a period sets that period's fault flag. The flag is the OR of both sides.
- FSM states: RUN, SHTDWN.
- RUN, on the clock where cnt==2047:
  - If the fault flag is set, consec = consec+1; otherwise consec = 0. Then clear the flag.
  - If consec reaches OVR_LIMIT, go to SHTDWN.
- SHTDWN:
  - OVR_I_shtdwn=1 and all four gate outputs are forced to 0 from the next clock.
  - cnt and PWM_synch keep running.
  - Only rst exits this state.
- Simultaneous events: a qualified fault on the clock where cnt==2047 counts toward the ending period. A fault outside the window, or with hi=0, is ignored.
- Reset mid-period: all outputs return to reset values on the next clock, and the counter restarts at 0.

Test Plan:
- Zero speed: lft_spd=rght_spd=0, DEAD=32 -> hi high for cnt 32..1023, lo high for cnt 1056..2047, both low for cnt 0..31 and 1024..1055. Timing is 1 clock after cnt, and never overlapping.
- Saturation: lft_spd=12'h7FF -> duty 2047, lo never high, hi high for cnt 32..2046. rght_spd=12'h800 -> duty 1, hi never high, lo high for cnt 33..2047.
- Mid-period update: change lft_spd from 0 to 512 at cnt=500 -> the current period still ends hi at cnt 1023. The next period ends hi at cnt 1535. PWM_synch pulses once per 2048 clocks.
- Blanking: assert OVR_I_lft for cnt 32..159 in every period -> consec stays 0 and OVR_I_shtdwn stays 0.
- Shutdown: assert OVR_I_lft at cnt=300 in 4 consecutive periods -> OVR_I_shtdwn=1 the clock after the 4th cnt==2047, all gates stay 0 thereafter. A clean period between faults resets the count, so no shutdown occurs.
- Reset: assert rst during SHTDWN at cnt=700 -> next clock all outputs are 0, cnt=0, duty=1024, and normal PWM resumes.
